// File: rtl/ld_ixy_from_mem_seq_pkg.sv
// Shared types and constants for the LD IX/IY,(nn) load sequencer and its decoder.
package ld_ixy_from_mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_NL = 3'd1,
    ST_RD_NH = 3'd2,
    ST_RD_DL = 3'd3,
    ST_RD_DH = 3'd4,
    ST_WB    = 3'd5
  } seq_state_t;

  localparam logic IXY_SEL_IX = 1'b0;
  localparam logic IXY_SEL_IY = 1'b1;

  // Opcode bytes the decoder matches before pulsing start.
  localparam logic [7:0] OPC_PREFIX_IX  = 8'hDD;
  localparam logic [7:0] OPC_PREFIX_IY  = 8'hFD;
  localparam logic [7:0] OPC_LD_IXY_MEM = 8'h2A;

endpackage

// File: rtl/ld_ixy_wait_timer.sv
// Per-access wait counter; expired pulses on the TIMEOUT_CYC-th consecutive wait cycle.
module ld_ixy_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate so a disabled timeout never wraps into a false compare.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && count && !clear && (cnt_q == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ld_ixy_from_mem_seq.sv
// LD IX,(nn) / LD IY,(nn): fetch nn at PC, read (nn) and (nn+1), write IX or IY.
// Handshake: mem_req/mem_addr hold steady until an edge with mem_ack=1; ack with mem_req=0 is ignored.
module ld_ixy_from_mem_seq
  import ld_ixy_from_mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                notRESET,
  input  logic                start,
  input  logic                iy_sel,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                pc_inc,
  output logic                ixy_we,
  output logic                ixy_sel,
  output logic [2*DATA_W-1:0] ixy_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output seq_state_t          dbg_state
);

  seq_state_t        state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] nn_q, nn_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              wait_cyc;
  logic              tmo_expired;

  assign wait_cyc = mem_req && !mem_ack;

  ld_ixy_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (notRESET),
    .clear  (!wait_cyc),
    .count  (wait_cyc),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    nn_d     = nn_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    pc_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = iy_sel;
          state_d = ST_RD_NL;
        end
      end
      ST_RD_NL: begin
        mem_req  = 1'b1;
        mem_addr = pc_in;
        if (mem_ack) begin
          nn_d[DATA_W-1:0] = mem_rdata;
          pc_inc           = 1'b1;
          state_d          = ST_RD_NH;
        end
      end
      ST_RD_NH: begin
        mem_req  = 1'b1;
        mem_addr = pc_in;
        if (mem_ack) begin
          nn_d[ADDR_W-1:DATA_W] = mem_rdata;
          pc_inc                = 1'b1;
          state_d               = ST_RD_DL;
        end
      end
      ST_RD_DL: begin
        mem_req  = 1'b1;
        mem_addr = nn_q;
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = ST_RD_DH;
        end
      end
      ST_RD_DH: begin
        mem_req  = 1'b1;
        mem_addr = nn_q + 1'b1;
        if (mem_ack) begin
          hi_d    = mem_rdata;
          we_d    = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Only fires on a cycle without ack, so a late ack always wins.
    if (tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      nn_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      nn_q    <= nn_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ixy_we    = we_q;
  assign done      = we_q;
  assign ixy_sel   = sel_q;
  assign ixy_wdata = {hi_q, lo_q};
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ld_ixy_from_mem_seq.sv
// Directed bench for ld_ixy_from_mem_seq: memory responder, PC model, per-scenario tasks.
module tb_ld_ixy_from_mem_seq;
  import ld_ixy_from_mem_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        notRESET = 1'b0;
  logic        start = 1'b0;
  logic        iy_sel = 1'b0;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        pc_inc;
  logic        ixy_we;
  logic        ixy_sel;
  logic [15:0] ixy_wdata;
  logic        busy;
  logic        done;
  logic        err;
  seq_state_t  dbg_state;

  ld_ixy_from_mem_seq #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(4)
  ) dut (
    .CLK(CLK), .notRESET(notRESET), .start(start), .iy_sel(iy_sel), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_inc(pc_inc), .ixy_we(ixy_we), .ixy_sel(ixy_sel), .ixy_wdata(ixy_wdata),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // memory model and responder
  logic [7:0] mem [0:65535];
  int  ack_delay = 0;
  int  acks_left = -1;
  bit  ack_idle  = 1'b0;
  int  wait_cnt  = 0;

  // PC owner model: increments on the edge following a pc_inc cycle
  logic        inc_pend = 1'b0;
  logic [15:0] pc_cnt   = 16'h0;
  logic [15:0] pc_base  = 16'h0;
  logic [15:0] pc_mark  = 16'h0;
  assign pc_in = pc_base + (pc_cnt - pc_mark);
  always @(posedge CLK) if (inc_pend) pc_cnt <= pc_cnt + 16'd1;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // observed activity
  logic [15:0] acc_q[$];
  logic [15:0] exp_q[$];
  int          n_pc_inc = 0, n_we = 0, n_err = 0, n_busy = 0, n_unstable = 0, n_done_diff = 0;
  int          we_cyc = 0, err_cyc = 0, s_cyc = 0;
  logic [15:0] we_data = 16'h0;
  logic        we_sel = 1'b0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  always @(negedge CLK) begin
    if (mem_req && (wait_cnt >= ack_delay) && (acks_left != 0)) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else begin
      mem_ack   = ack_idle && !mem_req;
      mem_rdata = 8'h5A;
    end
    #1;
    inc_pend = pc_inc;
    if (pc_inc) n_pc_inc++;
    if (busy) n_busy++;
    if (done !== ixy_we) n_done_diff++;
    if (err) begin n_err++; err_cyc = cyc; end
    if (ixy_we) begin n_we++; we_cyc = cyc; we_data = ixy_wdata; we_sel = ixy_sel; end
    if (mem_req && prev_wait && (mem_addr !== prev_addr)) n_unstable++;
    if (mem_req && mem_ack) begin
      acc_q.push_back(mem_addr);
      if (acks_left > 0) acks_left--;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;
  end

  // driver tasks
  task automatic set_pc(input logic [15:0] pc);
    pc_base = pc;
    pc_mark = pc_cnt;
  endtask

  task automatic pulse_start(input logic sel);
    @(negedge CLK);
    start  = 1'b1;
    iy_sel = sel;
    s_cyc  = cyc;
    @(negedge CLK);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge CLK); #2;
      k++;
    end while (busy && (k < budget));
    n_checks++;
    if (busy) $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    else n_pass++;
  endtask

  task automatic check_addrs(input string name);
    logic [15:0] got;
    n_checks++;
    if (acc_q.size() != exp_q.size())
      $display("FAIL %s_count: got %0d accesses, required %0d", name, acc_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < acc_q.size()) ? acc_q[i] : 16'hDEAD;
      n_checks++;
      if (got !== exp_q[i]) $display("FAIL %s_addr%0d: got %h, required %h", name, i, got, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic load_ref_data();
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
  endtask

  // scenarios
  task automatic test_reset();
    notRESET = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    n_checks++;
    if ({mem_req, pc_inc, ixy_we, ixy_sel, busy, done, err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, required 0000000", {mem_req, pc_inc, ixy_we, ixy_sel, busy, done, err});
    else n_pass++;
    n_checks++;
    if ({ixy_wdata, mem_addr} !== 32'h0) $display("FAIL reset_data: got %h, required 0", {ixy_wdata, mem_addr});
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    else n_pass++;
    @(negedge CLK);
    notRESET = 1'b1;
  endtask

  task automatic test_zero_wait_ix();
    int pc0, we0, busy0;
    load_ref_data();
    set_pc(16'h0100);
    ack_delay = 0; ack_idle = 1'b1;
    pc0 = n_pc_inc; busy0 = n_busy;
    acc_q.delete();
    repeat (3) @(negedge CLK);
    #2;
    n_checks++;
    if ((n_pc_inc != pc0) || (n_busy != busy0) || (acc_q.size() != 0))
      $display("FAIL idle_ack: pc_inc %0d busy %0d acc %0d, required 0 0 0", n_pc_inc - pc0, n_busy - busy0, acc_q.size());
    else n_pass++;
    we0 = n_we; n_done_diff = 0;
    exp_q = '{16'h0100, 16'h0101, 16'h1234, 16'h1235};
    pulse_start(IXY_SEL_IX);
    wait_idle(20);
    check_addrs("zw");
    n_checks++;
    if (n_pc_inc - pc0 != 2) $display("FAIL zw_pc_inc: got %0d, required 2", n_pc_inc - pc0); else n_pass++;
    n_checks++;
    if (n_we - we0 != 1) $display("FAIL zw_we_count: got %0d, required 1", n_we - we0); else n_pass++;
    n_checks++;
    if ((we_data !== 16'hABCD) || (we_sel !== 1'b0))
      $display("FAIL zw_write: got %h sel %b, required abcd sel 0", we_data, we_sel);
    else n_pass++;
    n_checks++;
    if (we_cyc - s_cyc != 5) $display("FAIL zw_latency: got %0d, required 5", we_cyc - s_cyc); else n_pass++;
    n_checks++;
    if (n_busy - busy0 != 5) $display("FAIL zw_busy: got %0d, required 5", n_busy - busy0); else n_pass++;
    n_checks++;
    if (n_done_diff != 0) $display("FAIL zw_done: got %0d differing cycles, required 0", n_done_diff); else n_pass++;
    n_checks++;
    if (pc_in !== 16'h0102) $display("FAIL zw_pc: got %h, required 0102", pc_in); else n_pass++;
    ack_idle = 1'b0;
  endtask

  task automatic test_wait_iy();
    int busy0;
    load_ref_data();
    set_pc(16'h0100);
    ack_delay = 3;
    acc_q.delete(); n_unstable = 0; busy0 = n_busy;
    exp_q = '{16'h0100, 16'h0101, 16'h1234, 16'h1235};
    pulse_start(IXY_SEL_IY);
    wait_idle(40);
    check_addrs("ws");
    n_checks++;
    if ((we_data !== 16'hABCD) || (we_sel !== 1'b1))
      $display("FAIL ws_write: got %h sel %b, required abcd sel 1", we_data, we_sel);
    else n_pass++;
    n_checks++;
    if (we_cyc - s_cyc != 17) $display("FAIL ws_latency: got %0d, required 17", we_cyc - s_cyc); else n_pass++;
    n_checks++;
    if (n_unstable != 0) $display("FAIL ws_addr_stable: got %0d changes, required 0", n_unstable); else n_pass++;
    n_checks++;
    if (n_busy - busy0 != 17) $display("FAIL ws_busy: got %0d, required 17", n_busy - busy0); else n_pass++;
    ack_delay = 0;
  endtask

  task automatic test_wrap();
    mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'hFF;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    set_pc(16'h0200);
    acc_q.delete();
    exp_q = '{16'h0200, 16'h0201, 16'hFFFF, 16'h0000};
    pulse_start(IXY_SEL_IX);
    wait_idle(20);
    check_addrs("wrap");
    n_checks++;
    if (we_data !== 16'h2211) $display("FAIL wrap_data: got %h, required 2211", we_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int we0, busy0;
    load_ref_data();
    set_pc(16'h0100);
    acc_q.delete(); we0 = n_we; busy0 = n_busy;
    @(negedge CLK); start = 1'b1; iy_sel = 1'b0; s_cyc = cyc;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK); start = 1'b1; iy_sel = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); start = 1'b1; iy_sel = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    n_checks++;
    if (n_we - we0 != 1) $display("FAIL b2b_we_count: got %0d, required 1", n_we - we0); else n_pass++;
    n_checks++;
    if ((we_sel !== 1'b0) || (we_data !== 16'hABCD))
      $display("FAIL b2b_write: got %h sel %b, required abcd sel 0", we_data, we_sel);
    else n_pass++;
    n_checks++;
    if ((acc_q.size() != 4) || (n_busy - busy0 != 5))
      $display("FAIL b2b_ignored: acc %0d busy %0d, required 4 5", acc_q.size(), n_busy - busy0);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL b2b_state: got %0d, required %0d", dbg_state, ST_IDLE); else n_pass++;
    set_pc(16'h0100);
    we0 = n_we;
    pulse_start(IXY_SEL_IY);
    wait_idle(20);
    n_checks++;
    if ((n_we - we0 != 1) || (we_sel !== 1'b1) || (we_data !== 16'hABCD))
      $display("FAIL b2b_next: we %0d %h sel %b, required 1 abcd sel 1", n_we - we0, we_data, we_sel);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int pc0, we0, err0, busy0;
    load_ref_data();
    set_pc(16'h0100);
    acks_left = 1;
    acc_q.delete();
    pc0 = n_pc_inc; we0 = n_we; err0 = n_err; busy0 = n_busy;
    pulse_start(IXY_SEL_IX);
    wait_idle(20);
    repeat (2) @(negedge CLK);
    #2;
    n_checks++;
    if (n_err - err0 != 1) $display("FAIL tmo_err_count: got %0d, required 1", n_err - err0); else n_pass++;
    n_checks++;
    if (err_cyc - s_cyc != 6) $display("FAIL tmo_err_cycle: got %0d, required 6", err_cyc - s_cyc); else n_pass++;
    n_checks++;
    if (n_pc_inc - pc0 != 1) $display("FAIL tmo_pc_inc: got %0d, required 1", n_pc_inc - pc0); else n_pass++;
    n_checks++;
    if (n_we - we0 != 0) $display("FAIL tmo_no_write: got %0d, required 0", n_we - we0); else n_pass++;
    n_checks++;
    if ((n_busy - busy0 != 5) || (busy !== 1'b0))
      $display("FAIL tmo_busy: got %0d cycles busy=%b, required 5 busy=0", n_busy - busy0, busy);
    else n_pass++;
    acks_left = -1;
  endtask

  task automatic test_reset_mid();
    int we0;
    load_ref_data();
    set_pc(16'h0100);
    we0 = n_we;
    pulse_start(IXY_SEL_IY);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    n_checks++;
    if (dbg_state !== ST_RD_DH) $display("FAIL rst_mid_pre: state %0d, required %0d", dbg_state, ST_RD_DH); else n_pass++;
    notRESET = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, pc_inc, ixy_we, ixy_sel, busy, done, err} !== 7'b0)
      $display("FAIL rst_mid_ctrl: got %b, required 0000000", {mem_req, pc_inc, ixy_we, ixy_sel, busy, done, err});
    else n_pass++;
    n_checks++;
    if ((ixy_wdata !== 16'h0) || (dbg_state !== ST_IDLE))
      $display("FAIL rst_mid_data: wdata %h state %0d, required 0000 0", ixy_wdata, dbg_state);
    else n_pass++;
    repeat (2) @(negedge CLK);
    notRESET = 1'b1;
    repeat (2) @(negedge CLK);
    #2;
    n_checks++;
    if (n_we - we0 != 0) $display("FAIL rst_mid_no_write: got %0d, required 0", n_we - we0); else n_pass++;
    set_pc(16'h0100);
    pulse_start(IXY_SEL_IX);
    wait_idle(20);
    n_checks++;
    if ((n_we - we0 != 1) || (we_data !== 16'hABCD) || (we_sel !== 1'b0))
      $display("FAIL rst_mid_recover: we %0d %h sel %b, required 1 abcd sel 0", n_we - we0, we_data, we_sel);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_ix();
    test_wait_iy();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ld_ixy_from_mem_seq.md
Name: ld_ixy_from_mem_seq

Overview:
- Sequencer for LD IX,(nn) / LD IY,(nn), the load counterpart of the LD (nn),IX/IY store path.
- Started by the instruction decoder after the DD/FD 2A opcode fetch.
- Reads operand bytes nn low/high at PC, then memory bytes at nn and nn+1.
- Writes the assembled 16-bit value into IX or IY, then hands control back for the next opcode fetch.
- Sits between the instruction decoder, the memory bus interface and the index register file.

Parameters:
- ADDR_W, 16, address width; nn and the nn+1 increment wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data width; the result is 2*DATA_W bits.
- TIMEOUT_CYC, 255, maximum cycles waiting for mem_ack per access; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- notRESET  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse from the decoder: begin the sequence.
- iy_sel  in  1  sampled with start: 0 selects IX, 1 selects IY.
- pc_in  in  ADDR_W  current PC, used as the operand fetch address.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address, valid while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  read complete; may be high in the same cycle as mem_req.
- pc_inc  out  1  one-cycle pulse: increment PC after each operand byte.
- ixy_we  out  1  one-cycle write strobe to the index register file.
- ixy_sel  out  1  target of the write: 0=IX, 1=IY.
- ixy_wdata  out  2*DATA_W  {high byte, low byte}.
- busy  out  1  high whenever the sequencer is outside IDLE.
- done  out  1  one-cycle pulse coincident with ixy_we; the decoder sets CM1 from it.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE; all outputs 0; internal nn, data and wait-counter registers 0. notRESET low at any time, including mid-sequence, forces this immediately (asynchronous). No ixy_we is ever produced from an aborted sequence.
- States: IDLE, RD_NL, RD_NH, RD_DL, RD_DH, WB.
- IDLE: start=1 latches iy_sel and moves to RD_NL. start while busy=1 is ignored.
- RD_NL: mem_req=1, mem_addr=pc_in. On mem_ack: nn[7:0]<=mem_rdata, pc_inc=1 in that same cycle, next state RD_NH.
- RD_NH: mem_req=1, mem_addr=pc_in (already incremented by the PC owner). On mem_ack: nn[15:8]<=mem_rdata, pc_inc=1, next state RD_DL.
- RD_DL: mem_req=1, mem_addr=nn. On mem_ack: lo<=mem_rdata, next state RD_DH.
- RD_DH: mem_req=1, mem_addr=nn+1 mod 2^ADDR_W (FFFF -> 0000). On mem_ack: hi<=mem_rdata, next state WB.
- WB, one cycle: ixy_we=1, done=1, ixy_sel=latched iy_sel, ixy_wdata={hi,lo}; then IDLE. A start in the WB cycle is ignored.
- Handshake:
  - mem_addr is stable for the whole time mem_req is high.
  - mem_ack is sampled at the rising edge; ack while mem_req=0 is ignored.
  - Zero-wait case: start at edge 0, WB during cycle 5, busy for 5 cycles.
- Wait counter:
  - Reset to 0 on each state entry; increments every cycle the sequencer waits without ack.
  - When TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC: err=1 for one cycle, return to IDLE, no write, no further pc_inc.
  - Ack arriving on the same cycle as the timeout wins (counts as ack).
- Outputs are registered except mem_req, mem_addr and pc_inc, which are Moore/Mealy decodes of the state register.

Decomposition:
- Shared package:
  - state enum (IDLE..WB, 3-bit encoding);
  - IXY_SEL_IX=0 / IXY_SEL_IY=1 constants;
  - the DD/FD 2A opcode constants used by the decoder that drives start.
- Sub-module ld_ixy_wait_timer: wait counter plus timeout compare, with clear / count / expired ports. It is reused by the store-direction sequencer.

Test Plan:
- Zero-wait, IX:
  - Stimulus: pc_in=0x0100; memory [0100]=0x34, [0101]=0x12, [1234]=0xCD, [1235]=0xAB; ack always high; start, iy_sel=0.
  - Required: addresses 0100,0101,1234,1235 in order; two pc_inc pulses; ixy_we with ixy_sel=0, ixy_wdata=0xABCD, 5 cycles after start.
- IY with wait states: same data, iy_sel=1, ack delayed 3 cycles per access -> ixy_wdata=0xABCD, ixy_sel=1, done 17 cycles after start; mem_addr stable during every wait.
- Wrap-around: nn=0xFFFF, [FFFF]=0x11, [0000]=0x22 -> second data read at 0x0000; ixy_wdata=0x2211.
- Busy and repeated start: start pulsed again during RD_DL and during WB -> ignored; exactly one ixy_we; the next sequence starts only from IDLE.
- Timeout: TIMEOUT_CYC=4, ack withheld in RD_NH -> err pulse after 4 wait cycles, exactly one pc_inc, no ixy_we, busy drops to 0.
- Reset mid-operation: notRESET low during RD_DH -> all outputs 0 immediately, no write; after release, a new start completes normally.
